// File: rtl/hdpldadapt_tx_datapath_fifo_wrctl_pkg.sv
// ---------------------------------------------------------------------------
// hdpldadapt_tx_datapath_fifo_wrctl_pkg
//
// Purpose: shared constants and pointer helper functions for the TX datapath
// FIFO write controller.
//
// The helpers work on a fixed maximum width (MAX_PW / MAX_AWIDTH). Callers
// zero-extend their narrower pointer into the helper and cast the result back
// down to their own width. Because the extra high bits are zero, the Gray
// conversions and the one-hot decode give the same low bits as a
// native-width version would. Pointers of up to MAX_AWIDTH address bits are
// supported.
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_AWIDTH  default FIFO geometry
//   bin2gray()                      binary -> reflected Gray
//   gray2bin()                      reflected Gray -> binary
//   onehot_decode()                 index -> one-hot vector
// ---------------------------------------------------------------------------
package hdpldadapt_tx_datapath_fifo_wrctl_pkg;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_AWIDTH = 4;

  // Largest supported geometry for the width-generic helpers below.
  localparam int MAX_AWIDTH = 8;
  localparam int MAX_PW     = MAX_AWIDTH + 1;
  localparam int MAX_DEPTH  = 1 << MAX_AWIDTH;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB downwards.
  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] gray);
    logic [MAX_PW-1:0] bin;
    bin[MAX_PW-1] = gray[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // One-hot decode of an entry index.
  function automatic logic [MAX_DEPTH-1:0] onehot_decode(input logic [MAX_AWIDTH-1:0] idx);
    logic [MAX_DEPTH-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/hdpldadapt_tx_datapath_fifo_wrctl_if.sv
// ---------------------------------------------------------------------------
// hdpldadapt_tx_datapath_fifo_wrctl_if
//
// Purpose: bundles the write request, static configuration, the synchronized
// read pointer and all write-side status outputs of the TX FIFO write
// controller. Clock and reset are not part of the bundle.
//
// Signals:
//   wr_req            upstream has a write this cycle
//   r_double_write    each accepted request writes 2 consecutive entries
//   r_stop_write      1 = block writes when full, 0 = overwrite when full
//   r_pfull_thresh    partial-full threshold in entries
//   rd_ptr_gray_sync  Gray read pointer, already in the write clock domain
//   wr_en             RAM write enable
//   wr_ptr            one-hot RAM write pointer
//   wr_ptr_gray       registered Gray write pointer for the read domain
//   wr_full           FIFO full
//   wr_pfull          occupancy >= r_pfull_thresh
//   wr_overflow       sticky: a write was accepted while full
//   wr_occ            current occupancy, 0..DEPTH
//
// Modports:
//   master  upstream / configuration side (drives requests, reads status)
//   slave   the write controller itself
// ---------------------------------------------------------------------------
interface hdpldadapt_tx_datapath_fifo_wrctl_if
  import hdpldadapt_tx_datapath_fifo_wrctl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AWIDTH = DEFAULT_AWIDTH
) ();

  logic              wr_req;
  logic              r_double_write;
  logic              r_stop_write;
  logic [AWIDTH:0]   r_pfull_thresh;
  logic [AWIDTH:0]   rd_ptr_gray_sync;

  logic              wr_en;
  logic [DEPTH-1:0]  wr_ptr;
  logic [AWIDTH:0]   wr_ptr_gray;
  logic              wr_full;
  logic              wr_pfull;
  logic              wr_overflow;
  logic [AWIDTH:0]   wr_occ;

  modport master (
    output wr_req, r_double_write, r_stop_write, r_pfull_thresh, rd_ptr_gray_sync,
    input  wr_en, wr_ptr, wr_ptr_gray, wr_full, wr_pfull, wr_overflow, wr_occ
  );

  modport slave (
    input  wr_req, r_double_write, r_stop_write, r_pfull_thresh, rd_ptr_gray_sync,
    output wr_en, wr_ptr, wr_ptr_gray, wr_full, wr_pfull, wr_overflow, wr_occ
  );

endinterface

// File: rtl/hdpldadapt_tx_datapath_fifo_ptr.sv
// ---------------------------------------------------------------------------
// hdpldadapt_tx_datapath_fifo_ptr
//
// Purpose: write pointer register set for the TX datapath FIFO. It keeps the
// binary pointer (with wrap bit), the Gray copy for the read domain and the
// one-hot RAM pointer in lock-step. On adv_en the pointer moves forward by 1,
// or by 2 when step_two is set.
//
// Ports:
//   clk       write clock
//   rst_n     asynchronous active-low reset
//   adv_en    advance the pointer this cycle (a write is happening)
//   step_two  advance by 2 instead of 1 (double-write mode)
//   bin_next  combinational post-update binary pointer (for occupancy)
//   gray_q    registered Gray pointer
//   onehot_q  registered one-hot RAM pointer
// ---------------------------------------------------------------------------
module hdpldadapt_tx_datapath_fifo_ptr
  import hdpldadapt_tx_datapath_fifo_wrctl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AWIDTH = DEFAULT_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_en,
  input  logic              step_two,
  output logic [AWIDTH:0]   bin_next,
  output logic [AWIDTH:0]   gray_q,
  output logic [DEPTH-1:0]  onehot_q
);

  localparam int PW = AWIDTH + 1;

  logic [PW-1:0]    bin_q;
  logic [PW-1:0]    bin_d;
  logic [PW-1:0]    gray_d;
  logic [DEPTH-1:0] onehot_d;

  // Next-state for the three pointer views. The Gray and one-hot values are
  // derived from the new binary value rather than stepped on their own. This
  // keeps all three views consistent by construction, including across the
  // wrap from DEPTH-1 back to entry 0 where the wrap bit toggles.
  always_comb begin
    bin_d    = bin_q;
    gray_d   = gray_q;
    onehot_d = onehot_q;
    if (adv_en) begin
      bin_d    = bin_q + (step_two ? PW'(2) : PW'(1));
      gray_d   = PW'(bin2gray(MAX_PW'(bin_d)));
      onehot_d = DEPTH'(onehot_decode(MAX_AWIDTH'(bin_d[AWIDTH-1:0])));
    end
  end

  assign bin_next = bin_d;

  // Pointer registers. Reset parks the pointer on entry 0 with the wrap bit
  // clear, so the one-hot pointer resets to bit 0 and not to all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      gray_q   <= '0;
      onehot_q <= DEPTH'(1);
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      onehot_q <= onehot_d;
    end
  end

endmodule

// File: rtl/hdpldadapt_tx_datapath_fifo_wrctl.sv
// ---------------------------------------------------------------------------
// hdpldadapt_tx_datapath_fifo_wrctl
//
// Purpose: write-side controller for the TX datapath FIFO RAM. It accepts
// write requests and drives the RAM write enable and one-hot write pointer.
// It tracks occupancy against the synchronized read pointer and produces
// full, partial-full, sticky overflow and occupancy. It also exports a
// registered Gray write pointer to the read domain.
//
// Ports:
//   wr_clk    write-domain clock
//   wr_rst_n  asynchronous active-low reset. Deassertion is expected to be
//             synchronized to wr_clk by the reset tree upstream.
//   bus       slave side of hdpldadapt_tx_datapath_fifo_wrctl_if
//             (request, configuration, read pointer in; RAM controls and
//             status out)
// ---------------------------------------------------------------------------
module hdpldadapt_tx_datapath_fifo_wrctl
  import hdpldadapt_tx_datapath_fifo_wrctl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AWIDTH = DEFAULT_AWIDTH
) (
  input  logic                                   wr_clk,
  input  logic                                   wr_rst_n,
  hdpldadapt_tx_datapath_fifo_wrctl_if.slave     bus
);

  localparam int            PW      = AWIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [PW-1:0] step;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] occ_next;
  logic          wr_en;

  logic          wr_full_q,     wr_full_d;
  logic          wr_pfull_q,    wr_pfull_d;
  logic          wr_overflow_q, wr_overflow_d;
  logic [PW-1:0] wr_occ_q,      wr_occ_d;

  assign step   = bus.r_double_write ? PW'(2) : PW'(1);
  assign rd_bin = PW'(gray2bin(MAX_PW'(bus.rd_ptr_gray_sync)));

  // Blocking on full only applies when r_stop_write is set. Otherwise the
  // write goes through and overwrites the oldest data. Reset gates the enable
  // so the RAM sees no write while the controller is held in reset.
  assign wr_en = bus.wr_req & wr_rst_n & (~wr_full_q | ~bus.r_stop_write);

  hdpldadapt_tx_datapath_fifo_ptr #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ptr (
    .clk      (wr_clk),
    .rst_n    (wr_rst_n),
    .adv_en   (wr_en),
    .step_two (bus.r_double_write),
    .bin_next (wr_bin_next),
    .gray_q   (bus.wr_ptr_gray),
    .onehot_q (bus.wr_ptr)
  );

  // Flag next-state. Occupancy is taken from the post-write pointer, so the
  // registered flags already reflect this cycle's write. A request in the
  // cycle right after the FIFO fills is therefore blocked. A read and a
  // write in the same cycle also net out correctly. Full is raised as soon
  // as fewer than one step of free space remains; in double-write mode that
  // means fewer than 2 free entries. Occupancy past DEPTH only happens after
  // an overwrite, so it is clamped. Overflow latches any write made while
  // full and only reset clears it.
  always_comb begin
    occ_next      = wr_bin_next - rd_bin;
    wr_occ_d      = (occ_next > DEPTH_C) ? DEPTH_C : occ_next;
    wr_full_d     = (occ_next > (DEPTH_C - step));
    wr_pfull_d    = (occ_next >= bus.r_pfull_thresh);
    wr_overflow_d = wr_overflow_q | (wr_en & wr_full_q);
  end

  // Status registers, cleared immediately by reset.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_full_q     <= 1'b0;
      wr_pfull_q    <= 1'b0;
      wr_overflow_q <= 1'b0;
      wr_occ_q      <= '0;
    end else begin
      wr_full_q     <= wr_full_d;
      wr_pfull_q    <= wr_pfull_d;
      wr_overflow_q <= wr_overflow_d;
      wr_occ_q      <= wr_occ_d;
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.wr_full     = wr_full_q;
  assign bus.wr_pfull    = wr_pfull_q;
  assign bus.wr_overflow = wr_overflow_q;
  assign bus.wr_occ      = wr_occ_q;

endmodule
